// File: rtl/ccff_io_config_sequencer.sv
// Serializes bitstream words LSB-first into the I/O-tile ccff chain and keeps pads isolated until loaded.
// Optional CRC-8 readback of the chain is compiled in with `define CCFF_READBACK_VERIFY_EN.
module ccff_io_config_sequencer #(
  parameter int CHAIN_LEN = 12,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en,
  output logic              config_enable,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int ACC_W  = $clog2(CHAIN_LEN + WORD_W + 1);
  localparam int PEND_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [ACC_W-1:0]  CHAIN_ACC = ACC_W'(CHAIN_LEN);
  localparam logic [ACC_W-1:0]  WORD_ACC  = ACC_W'(WORD_W);
  localparam logic [PEND_W-1:0] WORD_PEND = PEND_W'(WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
`ifdef CCFF_READBACK_VERIFY_EN
    VERIFY,
`endif
    DONE
  } state_t;

  state_t              r_state, w_next;
  logic [WORD_W-1:0]   r_sr;
  logic [PEND_W-1:0]   r_pend;
  logic [CNT_W-1:0]    r_bitcnt;
  logic [ACC_W-1:0]    r_acc;
  logic                r_settle;
  logic                w_start, w_shift, w_ready, w_accept, w_last_shift, w_error;

  assign w_start      = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_shift      = (r_state == LOAD) && (r_pend != '0);
  // Ready while empty or on the final pending bit, so the next word follows without a bubble.
  assign w_ready      = (r_state == LOAD) && (r_pend <= PEND_W'(1)) && (r_acc < CHAIN_ACC);
  assign w_accept     = w_ready && word_valid;
  assign w_last_shift = w_shift && (r_bitcnt == LAST_BIT);

`ifdef CCFF_READBACK_VERIFY_EN
  logic [7:0] r_crc_load, r_crc_rb, w_crc_rb_next;
  logic       r_error, w_vlast;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  assign w_crc_rb_next = crc8_step(r_crc_rb, ccff_tail);
  assign w_vlast       = (r_state == VERIFY) && (r_bitcnt == LAST_BIT);
  assign w_error       = r_error;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_crc_load <= '0;
      r_crc_rb   <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_start) begin
        r_crc_load <= '0;
        r_crc_rb   <= '0;
        r_error    <= 1'b0;
      end
      if (w_shift)            r_crc_load <= crc8_step(r_crc_load, r_sr[0]);
      if (r_state == VERIFY)  r_crc_rb   <= w_crc_rb_next;
      if (w_vlast)            r_error    <= (w_crc_rb_next != r_crc_load);
    end
  end
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
  assign w_error       = 1'b0;
`endif

  assign error = w_error;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (start) w_next = LOAD;
      LOAD:   if (w_last_shift) w_next = SETTLE;
`ifdef CCFF_READBACK_VERIFY_EN
      SETTLE: if (r_settle) w_next = VERIFY;
      VERIFY: if (w_vlast) w_next = DONE;
`else
      SETTLE: if (r_settle) w_next = DONE;
`endif
      DONE:   if (start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    word_ready    = 1'b0;
    ccff_head     = 1'b0;
    chain_clk_en  = 1'b0;
    config_enable = 1'b0;
    IO_ISOL_N     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      LOAD: begin
        busy          = 1'b1;
        config_enable = 1'b1;
        word_ready    = w_ready;
        chain_clk_en  = w_shift;
        ccff_head     = w_shift & r_sr[0];
      end
      SETTLE: begin
        busy          = 1'b1;
        config_enable = 1'b1;
      end
`ifdef CCFF_READBACK_VERIFY_EN
      VERIFY: begin
        busy          = 1'b1;
        config_enable = 1'b1;
        chain_clk_en  = 1'b1;
        ccff_head     = ccff_tail;
      end
`endif
      DONE: begin
        done      = 1'b1;
        IO_ISOL_N = !w_error;
      end
      default: ;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_sr     <= '0;
      r_pend   <= '0;
      r_bitcnt <= '0;
      r_acc    <= '0;
      r_settle <= 1'b0;
    end else begin
      if (w_start) begin
        r_pend   <= '0;
        r_bitcnt <= '0;
        r_acc    <= '0;
      end
      if (w_shift) begin
        r_sr     <= r_sr >> 1;
        r_pend   <= r_pend - PEND_W'(1);
        r_bitcnt <= r_bitcnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_sr   <= word_data;
        r_pend <= WORD_PEND;
        r_acc  <= r_acc + WORD_ACC;
      end
      // Chain full: drop the padding bits and rearm the counter for readback.
      if (w_last_shift) begin
        r_pend   <= '0;
        r_bitcnt <= '0;
      end
`ifdef CCFF_READBACK_VERIFY_EN
      if (r_state == VERIFY) r_bitcnt <= r_bitcnt + CNT_W'(1);
`endif
      r_settle <= (r_state == SETTLE) && !r_settle;
    end
  end

endmodule

// File: tb/tb_ccff_io_config_sequencer.sv
// Directed bench for ccff_io_config_sequencer (CHAIN_LEN=12, WORD_W=8) with a behavioural chain model.
module tb_ccff_io_config_sequencer;

  logic       prog_clk = 1'b0;
  logic       pReset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] word_data = '0;
  logic       word_valid = 1'b0;
  logic       word_ready, ccff_head, ccff_tail, chain_clk_en, config_enable;
  logic       IO_ISOL_N, busy, done, error;

  int tests = 0;
  int fails = 0;

  ccff_io_config_sequencer #(.CHAIN_LEN(12), .WORD_W(8)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .chain_clk_en(chain_clk_en),
    .config_enable(config_enable), .IO_ISOL_N(IO_ISOL_N), .busy(busy),
    .done(done), .error(error)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: 12 ccff cells, head enters at the top, tail leaves from bit 0.
  logic [11:0] chain = '0;
  int          shift_cnt = 0;
  int          fault_at = -1;
  logic        fault_en = 1'b0;
  always @(posedge prog_clk) begin
    if (chain_clk_en) begin
      chain     <= {ccff_head, chain[11:1]};
      shift_cnt <= shift_cnt + 1;
    end
  end
  assign ccff_tail = chain[0] ^ (fault_en && (shift_cnt == fault_at));

`ifdef CCFF_READBACK_VERIFY_EN
  localparam int          EXP_DONE       = 27;
  localparam int          EXP_DONE_STALL = 32;
  localparam int          EXP_NEN        = 24;
  localparam logic [63:0] EXP_MASK       = 64'h0000_0000_07FF_9FFE;
  localparam logic [63:0] EXP_MASK_STALL = 64'h0000_0000_FFF3_C1FE;
`else
  localparam int          EXP_DONE       = 15;
  localparam int          EXP_DONE_STALL = 20;
  localparam int          EXP_NEN        = 12;
  localparam logic [63:0] EXP_MASK       = 64'h0000_0000_0000_1FFE;
  localparam logic [63:0] EXP_MASK_STALL = 64'h0000_0000_0003_C1FE;
`endif

  logic [11:0] r_bits;
  logic [63:0] r_mask;
  logic [2:0]  r_c0;
  int          r_nen, r_done_c, r_isol_c, r_rises, r_acc;

  // Runs one sequence: start sampled at E0, iteration c samples the cycle after Ec.
  task automatic run_seq(input logic [7:0] w0, input logic [7:0] w1, input bit stall, input bit poke);
    int   idx;
    bit   hs, prev;
    idx = 0; hs = 0; prev = 0;
    r_bits = '0; r_mask = '0; r_c0 = '0;
    r_nen = 0; r_done_c = -1; r_isol_c = -1; r_rises = 0; r_acc = 0;
    @(negedge prog_clk);
    start = 1'b1; word_valid = 1'b1; word_data = w0;
    for (int c = 0; c < 48; c++) begin
      @(posedge prog_clk);
      if (hs) begin idx++; r_acc++; end
      @(negedge prog_clk);
      start = poke && (c == 5 || c == 13);
      if (c == 0) r_c0 = {done, IO_ISOL_N, busy};
      if (chain_clk_en) begin
        if (r_nen < 12) r_bits[r_nen] = ccff_head;
        r_nen++;
        r_mask[c] = 1'b1;
      end
      if (done && r_done_c < 0) r_done_c = c;
      if (done && !prev) r_rises++;
      prev = done;
      if (IO_ISOL_N && r_isol_c < 0) r_isol_c = c;
      word_valid = (idx < 2) && !(stall && c >= 8 && c <= 12);
      word_data  = (idx == 0) ? w0 : w1;
      hs = word_valid && word_ready;
    end
    start = 1'b0; word_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({word_ready, ccff_head, chain_clk_en, config_enable, IO_ISOL_N, busy, done, error} !== 8'h00) begin
      fails++;
      $display("FAIL reset_asserted: outputs=%b required=00000000",
               {word_ready, ccff_head, chain_clk_en, config_enable, IO_ISOL_N, busy, done, error});
    end
    @(negedge prog_clk); pReset_n = 1'b1; word_valid = 1'b1; word_data = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      @(negedge prog_clk);
      tests++;
      if ({word_ready, ccff_head, chain_clk_en, config_enable, IO_ISOL_N, busy, done, error} !== 8'h00) begin
        fails++;
        $display("FAIL idle_outputs cycle %0d: outputs=%b required=00000000", i,
                 {word_ready, ccff_head, chain_clk_en, config_enable, IO_ISOL_N, busy, done, error});
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic test_streaming;
    run_seq(8'hA5, 8'h0F, 1'b0, 1'b0);
    tests++; if (r_bits !== 12'hFA5) begin fails++; $display("FAIL stream_bits: got %h required fa5", r_bits); end
    tests++; if (r_nen !== EXP_NEN) begin fails++; $display("FAIL stream_shifts: got %0d required %0d", r_nen, EXP_NEN); end
    tests++; if (r_mask !== EXP_MASK) begin fails++; $display("FAIL stream_en_mask: got %h required %h", r_mask, EXP_MASK); end
    tests++; if (r_done_c !== EXP_DONE) begin fails++; $display("FAIL stream_done_edge: got %0d required %0d", r_done_c, EXP_DONE); end
    tests++; if (r_isol_c !== EXP_DONE) begin fails++; $display("FAIL stream_isol_edge: got %0d required %0d", r_isol_c, EXP_DONE); end
    tests++; if (r_acc !== 2) begin fails++; $display("FAIL stream_words: got %0d required 2", r_acc); end
    tests++; if (r_c0 !== 3'b001) begin fails++; $display("FAIL stream_first_cycle {done,isol,busy}: got %b required 001", r_c0); end
    tests++; if ({done, IO_ISOL_N, busy, error, config_enable} !== 5'b11000) begin
      fails++; $display("FAIL stream_final {done,isol,busy,err,cfg}: got %b required 11000",
                        {done, IO_ISOL_N, busy, error, config_enable});
    end
  endtask

  task automatic test_back_to_back;
    // Started straight from DONE: done and isolation must drop in the first LOAD cycle.
    run_seq(8'h5A, 8'hC3, 1'b0, 1'b0);
    tests++; if (r_c0 !== 3'b001) begin fails++; $display("FAIL b2b_first_cycle {done,isol,busy}: got %b required 001", r_c0); end
    tests++; if (r_bits !== 12'h35A) begin fails++; $display("FAIL b2b_bits: got %h required 35a", r_bits); end
    tests++; if (r_nen !== EXP_NEN) begin fails++; $display("FAIL b2b_shifts: got %0d required %0d", r_nen, EXP_NEN); end
    tests++; if (r_done_c !== EXP_DONE) begin fails++; $display("FAIL b2b_done_edge: got %0d required %0d", r_done_c, EXP_DONE); end
  endtask

  task automatic test_stall;
    run_seq(8'hA5, 8'h0F, 1'b1, 1'b0);
    tests++; if (r_bits !== 12'hFA5) begin fails++; $display("FAIL stall_bits: got %h required fa5", r_bits); end
    tests++; if (r_mask !== EXP_MASK_STALL) begin fails++; $display("FAIL stall_en_mask: got %h required %h", r_mask, EXP_MASK_STALL); end
    tests++; if (r_done_c !== EXP_DONE_STALL) begin fails++; $display("FAIL stall_done_edge: got %0d required %0d", r_done_c, EXP_DONE_STALL); end
  endtask

  task automatic test_start_busy;
    run_seq(8'hA5, 8'h0F, 1'b0, 1'b1);
    tests++; if (r_nen !== EXP_NEN) begin fails++; $display("FAIL busy_start_shifts: got %0d required %0d", r_nen, EXP_NEN); end
    tests++; if (r_rises !== 1) begin fails++; $display("FAIL busy_start_done_pulses: got %0d required 1", r_rises); end
    tests++; if (r_done_c !== EXP_DONE) begin fails++; $display("FAIL busy_start_done_edge: got %0d required %0d", r_done_c, EXP_DONE); end
    tests++; if (r_bits !== 12'hFA5) begin fails++; $display("FAIL busy_start_bits: got %h required fa5", r_bits); end
  endtask

  task automatic test_reset_mid_load;
    @(negedge prog_clk); start = 1'b1; word_valid = 1'b1; word_data = 8'hA5;
    @(posedge prog_clk);
    @(negedge prog_clk); start = 1'b0;
    repeat (5) @(posedge prog_clk);
    @(negedge prog_clk);
    tests++; if ({busy, chain_clk_en} !== 2'b11) begin fails++; $display("FAIL midload_active {busy,en}: got %b required 11", {busy, chain_clk_en}); end
    pReset_n = 1'b0;
    #1;
    tests++;
    if ({word_ready, ccff_head, chain_clk_en, config_enable, IO_ISOL_N, busy, done, error} !== 8'h00) begin
      fails++;
      $display("FAIL midload_async_reset: outputs=%b required=00000000",
               {word_ready, ccff_head, chain_clk_en, config_enable, IO_ISOL_N, busy, done, error});
    end
    word_valid = 1'b0;
    @(negedge prog_clk); pReset_n = 1'b1;
    run_seq(8'hA5, 8'h0F, 1'b0, 1'b0);
    tests++; if (r_bits !== 12'hFA5) begin fails++; $display("FAIL reload_bits: got %h required fa5", r_bits); end
    tests++; if (r_nen !== EXP_NEN) begin fails++; $display("FAIL reload_shifts: got %0d required %0d", r_nen, EXP_NEN); end
    tests++; if (r_done_c !== EXP_DONE) begin fails++; $display("FAIL reload_done_edge: got %0d required %0d", r_done_c, EXP_DONE); end
  endtask

`ifdef CCFF_READBACK_VERIFY_EN
  task automatic test_readback;
    fault_en = 1'b0;
    run_seq(8'hA5, 8'h0F, 1'b0, 1'b0);
    tests++; if ({done, error, IO_ISOL_N} !== 3'b101) begin fails++; $display("FAIL rb_clean {done,err,isol}: got %b required 101", {done, error, IO_ISOL_N}); end
    tests++; if (r_done_c !== 27) begin fails++; $display("FAIL rb_clean_done_edge: got %0d required 27", r_done_c); end
    // Verify bit 3 is the 16th enabled shift of the run (12 load + 3 verify before it).
    @(negedge prog_clk);
    fault_at = shift_cnt + 15;
    fault_en = 1'b1;
    run_seq(8'hA5, 8'h0F, 1'b0, 1'b0);
    tests++; if ({done, error, IO_ISOL_N} !== 3'b110) begin fails++; $display("FAIL rb_fault {done,err,isol}: got %b required 110", {done, error, IO_ISOL_N}); end
    tests++; if (r_done_c !== 27) begin fails++; $display("FAIL rb_fault_done_edge: got %0d required 27", r_done_c); end
    tests++; if (r_isol_c !== -1) begin fails++; $display("FAIL rb_fault_isol: released at %0d required never", r_isol_c); end
    fault_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_streaming;
    test_back_to_back;
    test_stall;
    test_start_busy;
    test_reset_mid_load;
`ifdef CCFF_READBACK_VERIFY_EN
    test_readback;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ccff_io_config_sequencer.md
Name: ccff_io_config_sequencer

Overview:
- Sequences programming of the I/O-tile configuration chain. The chain is a series of ccff cells, one per iopad direction bit, clocked by prog_clk.
- Accepts bitstream words over a valid/ready stream and serializes them LSB-first onto ccff_head.
- Gates chain shifting through a clock enable.
- Holds IO isolation asserted (IO_ISOL_N low) until the chain is fully loaded, so pads never drive with partial configuration.

Parameters:
- CHAIN_LEN, 12: number of ccff bits in the chain (range 1..1024).
- WORD_W, 8: bitstream word width (range 1..32).

Ports:
- prog_clk  in  1  programming clock; all logic is on the rising edge.
- pReset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin (re)configuration.
- word_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- word_valid  in  1  word_data is valid.
- word_ready  out  1  sequencer accepts word_data this cycle.
- ccff_head  out  1  serial data into the chain.
- ccff_tail  in  1  serial data out of the chain; used only by the optional feature.
- chain_clk_en  out  1  enable for the gated prog_clk feeding the chain; one chain shift per enabled cycle.
- config_enable  out  1  chain configuration-enable.
- IO_ISOL_N  out  1  pad isolation, low = isolated.
- busy  out  1  sequence in progress.
- done  out  1  level; configuration complete.
- error  out  1  level; readback mismatch.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. pReset_n asserted mid-sequence aborts immediately; chain contents are then undefined, and IO_ISOL_N=0 and done=0.
- States: IDLE, LOAD, SETTLE, VERIFY (optional), DONE.
- IDLE:
  - busy=0, config_enable=0, chain_clk_en=0.
  - start=1 → LOAD; bit counter cleared; done and error cleared; IO_ISOL_N forced 0.
- LOAD:
  - busy=1, config_enable=1.
  - Internal shift register holds 0..WORD_W pending bits.
  - word_ready=1 when the shift register is empty, or is presenting its final pending bit, and total accepted bits < CHAIN_LEN.
  - Word accepted on an edge where word_valid & word_ready.
  - In each cycle with a pending bit: ccff_head = current bit, chain_clk_en=1, bit counter increments at the cycle's end.
  - Cycle with no pending bit (source stall): chain_clk_en=0, ccff_head=0.
  - Result: back-to-back words stream at 1 bit/cycle with no bubble.
  - When the bit counter reaches CHAIN_LEN, remaining bits of the last word are discarded (padding); word_ready drops → SETTLE.
  - Words required = ceil(CHAIN_LEN/WORD_W).
- SETTLE:
  - 2 cycles with config_enable=1 and chain_clk_en=0.
  - Then → VERIFY if the feature is compiled in, else → DONE.
- DONE:
  - done=1, busy=0, config_enable=0, IO_ISOL_N=1 (unless error=1).
  - start → LOAD, which drops IO_ISOL_N and done in the next cycle.
- start while busy=1: ignored.
- word_valid outside LOAD: ignored; word_ready=0.
- Timing, start sampled at edge E0 with word_valid held high:
  - Word 0 accepted at E1.
  - Bit k is on ccff_head in the cycle after E(1+k).
  - LOAD exits at E(1+CHAIN_LEN).
  - done=1 after E(3+CHAIN_LEN).
  - Example: CHAIN_LEN=12 gives done after E15.

Optional Feature:
- Macro: CCFF_READBACK_VERIFY_EN.
- With macro:
  - During LOAD, a bit-serial CRC-8 (poly 0x07, init 0x00) is computed over each bit driven on ccff_head.
  - VERIFY runs CHAIN_LEN cycles with chain_clk_en=1, config_enable=1 and ccff_head = ccff_tail (recirculation, so chain contents are restored).
  - A second CRC-8 runs over ccff_tail in those cycles.
  - Then → DONE. If the CRCs differ: error=1 and IO_ISOL_N stays 0.
  - Adds CHAIN_LEN cycles; CHAIN_LEN=12 gives done after E27.
- Without macro: no VERIFY state, error tied 0, ccff_tail unused.

Test Plan:
- Reset and idle: pReset_n low, then high, with no start → all outputs 0 for 20 cycles; word_ready=0 even with word_valid=1.
- Streaming load (CHAIN_LEN=12, WORD_W=8, macro off): start, then words 0xA5 and 0x0F with valid held high → ccff_head sequence 1,0,1,0,0,1,0,1,1,1,1,1. chain_clk_en high for exactly 12 cycles; upper 4 bits of the second word discarded; done and IO_ISOL_N rise after E15.
- Source stall: word_valid low for 5 cycles between the two words → chain_clk_en=0 during the gap; bit order unchanged; done after E20.
- Start while busy: start pulsed during LOAD and during SETTLE → no effect; exactly 12 enabled shifts; single done.
- Reset mid-load: pReset_n low after 5 bits → all outputs 0 asynchronously. A new start reloads the full 12 bits and done follows normally.
- Readback (macro on): chain model returns a faithful copy → error=0, done after E27. Fault injection flips tail bit 3 → error=1, done=1, IO_ISOL_N=0.
